// File: rtl/veerwolf_sw_debounce.sv
// Switch input conditioner: 2-FF synchroniser, per-channel debounce counters,
// rise/fall strobes and a sticky change-event mask with a valid/ready handshake.
module veerwolf_sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_evt_valid,
  output logic [WIDTH-1:0] o_evt_mask,
  input  logic             i_evt_ready
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0]         sync_r_q,  sync_r_d;
  logic [WIDTH-1:0]         sync_2r_q, sync_2r_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0]         sw_q,      sw_d;
  logic [WIDTH-1:0]         rise_q,    rise_d;
  logic [WIDTH-1:0]         fall_q,    fall_d;
  logic [WIDTH-1:0]         evt_mask_q, evt_mask_d;
  logic                     evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0]         new_evt;
  logic                     evt_accept;

  // A channel commits only after CNT_MAX+1 consecutive mismatching samples;
  // any matching sample restarts the count, so bounces never leak through.
  always_comb begin
    sync_r_d  = i_sw;
    sync_2r_d = sync_r_q;
    cnt_d     = cnt_q;
    sw_d      = sw_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_2r_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sw_d[i]   = sync_2r_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_2r_q[i];
        fall_d[i] = ~sync_2r_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Changes committing on the accept edge reload the mask, so none are lost.
  always_comb begin
    new_evt     = rise_d | fall_d;
    evt_accept  = evt_valid_q & i_evt_ready;
    evt_mask_d  = evt_accept ? new_evt : (evt_mask_q | new_evt);
    evt_valid_d = |evt_mask_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r_q    <= '0;
      sync_2r_q   <= '0;
      cnt_q       <= '0;
      sw_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      evt_mask_q  <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      sync_r_q    <= sync_r_d;
      sync_2r_q   <= sync_2r_d;
      cnt_q       <= cnt_d;
      sw_q        <= sw_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_mask_q  <= evt_mask_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign o_sw        = sw_q;
  assign o_rise      = rise_q;
  assign o_fall      = fall_q;
  assign o_evt_mask  = evt_mask_q;
  assign o_evt_valid = evt_valid_q;

endmodule

// File: tb/tb_veerwolf_sw_debounce.sv
// Scoreboard bench for veerwolf_sw_debounce (WIDTH=16, DEBOUNCE_CYCLES=4):
// expected output snapshots are queued per clock edge and compared on the falling edge.
module tb_veerwolf_sw_debounce;

  localparam int WIDTH = 16;
  localparam int DC    = 4;

  logic             clk;
  logic             rstn;
  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_evt_valid;
  logic [WIDTH-1:0] o_evt_mask;
  logic             i_evt_ready;

  typedef struct {
    int          edge_no;
    logic [64:0] vec;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   edge_cnt;

  veerwolf_sw_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_sw       (i_sw),
    .o_sw       (o_sw),
    .o_rise     (o_rise),
    .o_fall     (o_fall),
    .o_evt_valid(o_evt_valid),
    .o_evt_mask (o_evt_mask),
    .i_evt_ready(i_evt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Snapshot expected after rising edge number e.
  function automatic void push_exp(input int e, input logic [15:0] sw, input logic [15:0] rise,
                                   input logic [15:0] fall, input logic [15:0] mask,
                                   input logic valid, input string name);
    exp_t x;
    x.edge_no = e;
    x.vec     = {sw, rise, fall, mask, valid};
    x.name    = name;
    sb_q.push_back(x);
  endfunction

  // Pop entries whose edge has arrived and compare against the DUT outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
      exp_t x;
      x = sb_q.pop_front();
      checks++;
      if (x.edge_no < edge_cnt) begin
        errors++;
        $display("[TB] FAIL %s: entry for edge %0d not compared (now edge %0d)",
                 x.name, x.edge_no, edge_cnt);
      end else if ({o_sw, o_rise, o_fall, o_evt_mask, o_evt_valid} !== x.vec) begin
        errors++;
        $display("[TB] FAIL %s @edge %0d: got sw=%h rise=%h fall=%h mask=%h valid=%b, want sw=%h rise=%h fall=%h mask=%h valid=%b",
                 x.name, edge_cnt, o_sw, o_rise, o_fall, o_evt_mask, o_evt_valid,
                 x.vec[64:49], x.vec[48:33], x.vec[32:17], x.vec[16:1], x.vec[0]);
      end
    end
  end

  task automatic wait_scoreboard(input string name);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard not drained, %0d entries left, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic clear_events();
    @(negedge clk);
    i_evt_ready = 1'b1;
    @(negedge clk);
    i_evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    int r;
    rstn        = 1'b0;
    i_sw        = 16'hFFFF;
    i_evt_ready = 1'b0;
    #3;
    checks++;
    if ({o_sw, o_rise, o_fall, o_evt_mask, o_evt_valid} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL reset_initial: got sw=%h mask=%h valid=%b, want all 0", o_sw, o_evt_mask, o_evt_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({o_sw, o_rise, o_fall, o_evt_mask, o_evt_valid} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL reset_clocked: got sw=%h rise=%h mask=%h valid=%b, want all 0", o_sw, o_rise, o_evt_mask, o_evt_valid);
    end
    rstn = 1'b1;
    r = edge_cnt;
    push_exp(r + 5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, "poweron_before");
    push_exp(r + 6, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, "poweron_commit");
    push_exp(r + 7, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, "poweron_after");
    wait_scoreboard("poweron");
  endtask

  task automatic test_single_rise();
    int e0;
    i_sw = 16'h0000;
    repeat (8) @(negedge clk);
    clear_events();
    e0 = edge_cnt + 1;
    i_sw = 16'h0001;
    push_exp(e0 + 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, "rise_before");
    push_exp(e0 + 5, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 1'b1, "rise_commit");
    push_exp(e0 + 6, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b1, "rise_after");
    wait_scoreboard("single_rise");
  endtask

  task automatic test_bounce();
    int e0;
    clear_events();
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) i_sw[2] = ~i_sw[2];
      push_exp(edge_cnt + 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, "bounce_hold");
      @(negedge clk);
    end
    i_sw[2] = 1'b1;
    e0 = edge_cnt + 1;
    for (int k = 0; k < 5; k++)
      push_exp(e0 + k, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, "bounce_settle");
    push_exp(e0 + 5, 16'h0005, 16'h0004, 16'h0000, 16'h0004, 1'b1, "bounce_commit");
    push_exp(e0 + 6, 16'h0005, 16'h0000, 16'h0000, 16'h0004, 1'b1, "bounce_after");
    wait_scoreboard("bounce");
  endtask

  task automatic test_event_mask();
    int e0;
    i_sw = 16'h0008;
    repeat (8) @(negedge clk);
    clear_events();
    e0 = edge_cnt + 1;
    i_sw = 16'h0009;
    repeat (2) @(negedge clk);
    i_sw = 16'h0001;
    push_exp(e0 + 5, 16'h0009, 16'h0001, 16'h0000, 16'h0001, 1'b1, "mask_rise0");
    push_exp(e0 + 6, 16'h0009, 16'h0000, 16'h0000, 16'h0001, 1'b1, "mask_hold0");
    push_exp(e0 + 7, 16'h0001, 16'h0000, 16'h0008, 16'h0009, 1'b1, "mask_fall3");
    push_exp(e0 + 8, 16'h0001, 16'h0000, 16'h0000, 16'h0009, 1'b1, "mask_sticky");
    wait_scoreboard("event_mask");
    @(negedge clk);
    i_evt_ready = 1'b1;
    push_exp(edge_cnt + 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, "mask_accept");
    @(negedge clk);
    push_exp(edge_cnt + 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, "ready_idle");
    @(negedge clk);
    i_evt_ready = 1'b0;
    wait_scoreboard("event_accept");
  endtask

  task automatic test_back_to_back();
    int e0;
    @(negedge clk);
    i_sw = 16'h0008;
    e0 = edge_cnt + 1;
    @(negedge clk);
    i_sw = 16'h0028;
    push_exp(e0 + 5, 16'h0008, 16'h0008, 16'h0001, 16'h0009, 1'b1, "b2b_pending");
    push_exp(e0 + 6, 16'h0028, 16'h0020, 16'h0000, 16'h0020, 1'b1, "b2b_accept_new");
    push_exp(e0 + 7, 16'h0028, 16'h0000, 16'h0000, 16'h0020, 1'b1, "b2b_after");
    repeat (5) @(negedge clk);
    i_evt_ready = 1'b1;
    @(negedge clk);
    i_evt_ready = 1'b0;
    wait_scoreboard("back_to_back");
  endtask

  task automatic test_async_reset();
    int e0;
    int r;
    clear_events();
    i_sw = 16'h002A;
    repeat (8) @(negedge clk);
    clear_events();
    e0 = edge_cnt + 1;
    i_sw = 16'h0028;
    push_exp(e0 + 5, 16'h0028, 16'h0000, 16'h0002, 16'h0002, 1'b1, "rst_prep_fall1");
    wait_scoreboard("async_reset_prep");
    @(negedge clk);
    i_sw = 16'h002A;
    repeat (4) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_sw, o_rise, o_fall, o_evt_mask, o_evt_valid} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got sw=%h mask=%h valid=%b, want all 0", o_sw, o_evt_mask, o_evt_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    r = edge_cnt;
    push_exp(r + 5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, "rst_restart_before");
    push_exp(r + 6, 16'h002A, 16'h002A, 16'h0000, 16'h002A, 1'b1, "rst_restart_commit");
    push_exp(r + 7, 16'h002A, 16'h0000, 16'h0000, 16'h002A, 1'b1, "rst_restart_after");
    wait_scoreboard("async_reset");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rstn        = 1'b0;
    i_sw        = '0;
    i_evt_ready = 1'b0;
    test_reset();
    test_single_rise();
    test_bounce();
    test_event_mask();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
